// File: rtl/stim_cmd_parser.sv
// stim_cmd_parser
//   Assembles 9-byte stimulation command frames from the UART byte stream:
//     0xAA, mode, bfreq_hi, bfreq_lo, pfreq_hi, pfreq_lo, ton_hi, ton_lo, csum
//   csum is the modulo-256 sum of bytes 1..7. A frame is published to the
//   parameter outputs only if the checksum matches and every field is in range.
//   Otherwise the previous parameters stay active.
//
//   Optional feature (macro STIM_CMD_ACK_EN): one cycle after a frame is
//   accepted or rejected, tx_start pulses with an acknowledge byte on tx_data.
//   The byte is 0x55 on accept and 0xE0|err_code on reject. Without the macro,
//   tx_data and tx_start are tied to 0.
//
// Ports
//   sys_clk, sys_rst_n     clock and asynchronous active-low reset
//   rx_data, rx_valid      UART byte and its one-cycle strobe
//   stim_mode, burst_freq, pulse_freq, igbt_on_time
//                          published stimulation parameters
//   params_valid           set once any frame has been accepted
//   param_update           one-cycle strobe when the parameters change
//   frame_err, err_code    reject strobe and its cause
//                          (1 = checksum, 2 = range, 3 = timeout);
//                          err_code holds until the next reject
//   tx_data, tx_start      acknowledge byte and its send strobe
module stim_cmd_parser #(
  parameter int CLK_FREQ_MHZ    = 50,
  parameter int BYTE_TIMEOUT_US = 2000,
  parameter int MAX_MODE        = 4,
  parameter int MAX_PULSE_FREQ  = 100,
  parameter int MAX_ON_TIME_US  = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [3:0]  stim_mode,
  output logic [11:0] burst_freq,
  output logic [11:0] pulse_freq,
  output logic [15:0] igbt_on_time,
  output logic        params_valid,
  output logic        param_update,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  tx_data,
  output logic        tx_start
);

  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int GW = $clog2(BYTE_TIMEOUT_US + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, CHECK} state_t;

  state_t          state, state_nxt;
  logic [7:0]      rx_byte_q;
  logic            rx_vld_q;
  logic [6:0][7:0] sh;        // shadow copy of payload bytes 1..7
  logic [2:0]      idx;
  logic [7:0]      sum;
  logic            csum_ok;
  logic [PW-1:0]   presc;
  logic [GW-1:0]   gap;

  logic            frame_act, timeout, range_ok;
  logic            accept, reject;
  logic [1:0]      rej_code;
  logic [15:0]     bf, pf, ton;

  assign bf  = {sh[1], sh[2]};
  assign pf  = {sh[3], sh[4]};
  assign ton = {sh[5], sh[6]};

  // Upper nibble of each frequency hi byte must be zero, which also bounds
  // burst_freq to 4095.
  assign range_ok = (sh[0] <= 8'(MAX_MODE)) &&
                    (bf[15:12] == 4'd0) &&
                    (pf[15:12] == 4'd0) && (pf[11:0] != 12'd0) &&
                    (pf[11:0] <= 12'(MAX_PULSE_FREQ)) &&
                    (ton != 16'd0) && (ton <= 16'(MAX_ON_TIME_US));

  assign frame_act = (state == PAYLOAD) || (state == CSUM);
  assign timeout   = frame_act && (gap == GW'(BYTE_TIMEOUT_US));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    rej_code  = 2'd0;
    case (state)
      IDLE:    if (rx_vld_q && rx_byte_q == 8'hAA) state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (timeout) begin
          reject = 1'b1; rej_code = 2'd3; state_nxt = IDLE;
        end else if (rx_vld_q && idx == 3'd6) begin
          state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (timeout) begin
          reject = 1'b1; rej_code = 2'd3; state_nxt = IDLE;
        end else if (rx_vld_q) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Any byte seen here is dropped, header or not.
        state_nxt = IDLE;
        if (!csum_ok)       begin reject = 1'b1; rej_code = 2'd1; end
        else if (!range_ok) begin reject = 1'b1; rej_code = 2'd2; end
        else                accept = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The input bytes are registered before the FSM sees them. Outputs therefore
  // move two edges after the edge that samples the checksum byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_byte_q <= '0;
      rx_vld_q  <= 1'b0;
      sh        <= '0;
      idx       <= '0;
      sum       <= '0;
      csum_ok   <= 1'b0;
    end else begin
      rx_byte_q <= rx_data;
      rx_vld_q  <= rx_valid;
      case (state)
        IDLE: if (rx_vld_q && rx_byte_q == 8'hAA) begin
          idx <= '0;
          sum <= '0;
        end
        PAYLOAD: if (rx_vld_q && !timeout) begin
          sh[idx] <= rx_byte_q;
          sum     <= sum + rx_byte_q;
          idx     <= idx + 3'd1;
        end
        CSUM: if (rx_vld_q && !timeout) csum_ok <= (rx_byte_q == sum);
        default: ;
      endcase
    end
  end

  // Inter-byte gap timer. It is held at zero outside a frame and restarts on
  // every byte. The prescaler restarts with it, so the limit is an exact
  // number of clocks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
      gap   <= '0;
    end else if (!frame_act || rx_vld_q) begin
      presc <= '0;
      gap   <= '0;
    end else if (presc == PW'(CLK_FREQ_MHZ - 1)) begin
      presc <= '0;
      if (gap != GW'(BYTE_TIMEOUT_US)) gap <= gap + GW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stim_mode    <= '0;
      burst_freq   <= '0;
      pulse_freq   <= '0;
      igbt_on_time <= '0;
      params_valid <= 1'b0;
      param_update <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= '0;
    end else begin
      param_update <= accept;
      frame_err    <= reject;
      if (accept) begin
        stim_mode    <= sh[0][3:0];
        burst_freq   <= bf[11:0];
        pulse_freq   <= pf[11:0];
        igbt_on_time <= ton;
        params_valid <= 1'b1;
      end
      if (reject) err_code <= rej_code;
    end
  end

`ifdef STIM_CMD_ACK_EN
  // err_code is already updated when frame_err is high, so the reject byte
  // can be built directly from it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= param_update | frame_err;
      if (param_update)   tx_data <= 8'h55;
      else if (frame_err) tx_data <= {6'b111000, err_code};
    end
  end
`else
  assign tx_data  = 8'h00;
  assign tx_start = 1'b0;
`endif

endmodule

// File: tb/tb_stim_cmd_parser.sv
module tb_stim_cmd_parser;

  localparam int CLK_MHZ = 4;
  localparam int TO_US   = 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  stim_mode;
  logic [11:0] burst_freq, pulse_freq;
  logic [15:0] igbt_on_time;
  logic        params_valid, param_update, frame_err, tx_start;
  logic [1:0]  err_code;
  logic [7:0]  tx_data;

  stim_cmd_parser #(
    .CLK_FREQ_MHZ(CLK_MHZ), .BYTE_TIMEOUT_US(TO_US), .MAX_MODE(4),
    .MAX_PULSE_FREQ(100), .MAX_ON_TIME_US(1000)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .stim_mode(stim_mode), .burst_freq(burst_freq), .pulse_freq(pulse_freq),
    .igbt_on_time(igbt_on_time), .params_valid(params_valid), .param_update(param_update),
    .frame_err(frame_err), .err_code(err_code), .tx_data(tx_data), .tx_start(tx_start)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic            junk;
    logic [8:0][7:0] b;     // b[8] is the header, b[0] the checksum
    logic            ok;
    logic [1:0]      code;
    logic [3:0]      mode;
    logic [11:0]     bf, pf;
    logic [15:0]     ton;
  } vec_t;

  vec_t vecs[11];
  int   n_chk = 0, n_pass = 0;

  logic [3:0]  c_mode;
  logic [11:0] c_bf, c_pf;
  logic [15:0] c_ton;
  logic        c_pv;
  logic [1:0]  c_code;

  function automatic vec_t mk(input logic j, input logic [71:0] bytes, input logic ok,
                              input logic [1:0] code, input logic [3:0] m,
                              input logic [11:0] bf, input logic [11:0] pf,
                              input logic [15:0] t);
    vec_t v;
    v.junk = j; v.b = bytes; v.ok = ok; v.code = code;
    v.mode = m; v.bf = bf; v.pf = pf; v.ton = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge sys_clk); rx_valid = 1'b1; rx_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk); rx_valid = 1'b0;
    end
  endtask

  task automatic chk_outputs(input string nm);
    chk({nm, ".mode"}, 32'(stim_mode), 32'(c_mode));
    chk({nm, ".bfreq"}, 32'(burst_freq), 32'(c_bf));
    chk({nm, ".pfreq"}, 32'(pulse_freq), 32'(c_pf));
    chk({nm, ".ton"}, 32'(igbt_on_time), 32'(c_ton));
    chk({nm, ".pvalid"}, 32'(params_valid), 32'(c_pv));
    chk({nm, ".errcode"}, 32'(err_code), 32'(c_code));
  endtask

  task automatic chk_ack(input string nm, input logic ok);
`ifdef STIM_CMD_ACK_EN
    chk({nm, ".tx_start"}, 32'(tx_start), 32'd1);
    chk({nm, ".tx_data"}, 32'(tx_data), ok ? 32'h55 : 32'(8'hE0 | {6'd0, c_code}));
`else
    chk({nm, ".tx_start"}, 32'(tx_start), 32'd0);
    chk({nm, ".tx_data"}, 32'(tx_data), 32'd0);
`endif
  endtask

  // Sends a vector (idle cycles between bytes set by gap), then checks the
  // strobe timing and the resulting outputs.
  task automatic run_vec(input string nm, input vec_t v, input int gap);
    if (v.junk) begin
      drive(8'h12); idle(1); drive(8'h34); idle(1);
    end
    for (int i = 8; i >= 1; i--) begin
      drive(v.b[i]); idle(gap);
    end
    drive(v.b[0]);
    idle(1);
    chk({nm, ".early0"}, 32'({param_update, frame_err}), 32'd0);
    idle(1);
    chk({nm, ".early1"}, 32'({param_update, frame_err}), 32'd0);
    idle(1);
    chk({nm, ".update"}, 32'(param_update), 32'(v.ok));
    chk({nm, ".ferr"}, 32'(frame_err), 32'(!v.ok));
    if (v.ok) begin
      c_mode = v.mode; c_bf = v.bf; c_pf = v.pf; c_ton = v.ton; c_pv = 1'b1;
    end else begin
      c_code = v.code;
    end
    chk_outputs(nm);
    idle(1);
    chk({nm, ".oneshot"}, 32'({param_update, frame_err}), 32'd0);
    chk_ack(nm, v.ok);
  endtask

  task automatic watch(input int n, output int ups, output int errs);
    ups = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (param_update) ups++;
      if (frame_err) errs++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ups, errs, found;
    vecs[0]  = mk(0, 72'hAA_04_00_0A_00_64_00_64_D6, 1, 0, 4, 10, 100, 100);
    vecs[1]  = mk(0, 72'hAA_04_00_0A_00_64_00_64_D7, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 72'hAA_04_00_0A_00_65_00_64_D7, 0, 2, 0, 0, 0, 0);
    vecs[3]  = mk(0, 72'hAA_05_00_0A_00_64_00_64_D7, 0, 2, 0, 0, 0, 0);
    vecs[4]  = mk(0, 72'hAA_01_10_00_00_01_00_01_13, 0, 2, 0, 0, 0, 0);
    vecs[5]  = mk(0, 72'hAA_01_00_00_00_01_03_E9_EE, 0, 2, 0, 0, 0, 0);
    vecs[6]  = mk(0, 72'hAA_01_00_00_00_00_00_01_02, 0, 2, 0, 0, 0, 0);
    vecs[7]  = mk(0, 72'hAA_00_0F_FF_00_01_03_E8_FA, 1, 0, 0, 4095, 1, 1000);
    vecs[8]  = mk(0, 72'hAA_04_00_0A_00_65_00_64_D8, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 72'hAA_00_00_01_10_05_00_05_1B, 0, 2, 0, 0, 0, 0);
    vecs[10] = mk(1, 72'hAA_02_00_AA_00_32_01_F4_D3, 1, 0, 2, 170, 50, 500);

    c_mode = 0; c_bf = 0; c_pf = 0; c_ton = 0; c_pv = 0; c_code = 0;
    sys_rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk_outputs("reset");
    chk("reset.strobes", 32'({param_update, frame_err, tx_start}), 32'd0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1);
      idle(2);
    end

    // Header byte arriving right behind the checksum must be dropped.
    for (int i = 8; i >= 1; i--) begin
      drive(vecs[7].b[i]); idle(1);
    end
    drive(vecs[7].b[0]);
    drive(8'hAA);
    idle(2);
    chk("drop.update", 32'(param_update), 32'd1);
    c_mode = 0; c_bf = 4095; c_pf = 1; c_ton = 1000;
    for (int i = 7; i >= 0; i--) begin
      drive(vecs[0].b[i]); idle(1);
    end
    watch(10, ups, errs);
    chk("drop.no_update", 32'(ups), 32'd0);
    chk("drop.no_err", 32'(errs), 32'd0);
    chk_outputs("drop");

    // Timeout partway through a frame.
    drive(8'hAA); idle(1); drive(8'h04); idle(1); drive(8'h00); idle(1);
    watch((TO_US - 1) * CLK_MHZ, ups, errs);
    chk("to.not_early", 32'(errs), 32'd0);
    found = 0;
    for (int i = 0; i < 4 * CLK_MHZ + 10 && found == 0; i++) begin
      idle(1);
      if (frame_err) found = 1;
    end
    chk("to.ferr", 32'(found), 32'd1);
    c_code = 2'd3;
    chk_outputs("to");
    idle(1);
    chk_ack("to", 1'b0);
    idle(3);
    run_vec("to_next", vecs[0], 1);

    // Byte gaps just inside the timeout still form a valid frame.
    run_vec("slowgap", vecs[7], (TO_US - 1) * CLK_MHZ - 1);

    // Reset partway through a frame, then a clean frame.
    for (int i = 8; i >= 4; i--) begin
      drive(vecs[0].b[i]); idle(1);
    end
    @(negedge sys_clk); sys_rst_n = 1'b0;
    #2;
    c_mode = 0; c_bf = 0; c_pf = 0; c_ton = 0; c_pv = 0; c_code = 0;
    chk_outputs("rst_mid");
    chk("rst_mid.tx", 32'({tx_start, tx_data}), 32'd0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    idle(2);
    run_vec("after_rst", vecs[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
